// File: rtl/ifetch_queue.sv
// Instruction fetch unit with a credit-limited prefetch queue and redirect flush.
// Optional statistics counters are enabled with the IFQ_STATS_EN macro.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_dropped
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state_reg;
  logic [31:0]   fpc_reg;
  logic [31:0]   instr_mem  [DEPTH];
  logic [31:0]   pc_mem     [DEPTH];
  logic [31:0]   shadow_mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, sh_wr_reg, sh_rd_reg;
  logic [PW:0]   count_reg, outstanding_reg, drop_reg;
  logic [PW:0]   count_next, outstanding_next, drop_next;

  logic req_fire, resp_fire, resp_keep, consume, draining;

  // Credits cover both queued and in-flight words, so every response has a slot.
  assign imem_req_valid = ~rst & (({1'b0, count_reg} + {1'b0, outstanding_reg}) < DEPTH_W);
  assign imem_req_addr  = fpc_reg;

  assign draining  = (state_reg == DRAIN);
  assign req_fire  = imem_req_valid & imem_req_ready;
  assign resp_fire = imem_resp_valid & (outstanding_reg != '0);
  assign resp_keep = resp_fire & ~draining & ~redirect_valid;

  assign instr_valid = ~rst & (count_reg != '0);
  assign consume     = instr_valid & instr_ready & ~redirect_valid;
  assign instr       = instr_valid ? instr_mem[rd_ptr_reg] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_reg] : '0;

  always_comb begin
    outstanding_next = outstanding_reg + (PW+1)'(req_fire) - (PW+1)'(resp_fire);
    count_next       = count_reg + (PW+1)'(resp_keep) - (PW+1)'(consume);
    drop_next        = drop_reg - (PW+1)'(resp_fire & draining);
    if (redirect_valid) begin
      count_next = '0;
      drop_next  = outstanding_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      fpc_reg         <= RESET_PC;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      sh_wr_reg       <= '0;
      sh_rd_reg       <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_reg        <= '0;
    end else begin
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      if (req_fire)
        sh_wr_reg <= sh_wr_reg + PTR_ONE;
      if (resp_fire)
        sh_rd_reg <= sh_rd_reg + PTR_ONE;
      if (redirect_valid) begin
        fpc_reg    <= redirect_pc & 32'hFFFF_FFFC;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        state_reg  <= (drop_next != '0) ? DRAIN : RUN;
      end else begin
        if (req_fire)
          fpc_reg <= fpc_reg + 32'd4;
        if (resp_keep)
          wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (consume)
          rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        if (draining && drop_next == '0)
          state_reg <= RUN;
      end
    end
  end

  // Storage carries no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (req_fire)
      shadow_mem[sh_wr_reg] <= fpc_reg;
    if (resp_keep) begin
      instr_mem[wr_ptr_reg] <= imem_resp_data;
      pc_mem[wr_ptr_reg]    <= shadow_mem[sh_rd_reg];
    end
  end

`ifdef IFQ_STATS_EN
  logic [31:0] stat_fetched_reg, stat_dropped_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched_reg <= '0;
      stat_dropped_reg <= '0;
    end else begin
      if (resp_keep)
        stat_fetched_reg <= stat_fetched_reg + 32'd1;
      if (resp_fire & ~resp_keep)
        stat_dropped_reg <= stat_dropped_reg + 32'd1;
    end
  end

  assign stat_fetched = stat_fetched_reg;
  assign stat_dropped = stat_dropped_reg;
`endif

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch unit with a prefetch queue, directly upstream of the single-cycle `mips` core's decode/execute path. It owns the fetch program counter and issues word reads to instruction memory over a valid/ready request channel, accepting in-order responses of arbitrary latency. Returned instructions are buffered in a small FIFO and presented to the core with their PC. A branch or jump redirect from the core flushes the queue and discards stale in-flight responses.

## Interface
Parameters:
- `DEPTH`, 4: queue entries and maximum fetches in flight; power of two, 2–16.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_resp_valid` in 1: response data valid; always accepted, with no back-pressure.
- `imem_resp_data` in 32: returned instruction word.
- `redirect_valid` in 1: core requests a new fetch stream.
- `redirect_pc` in 32: new stream address; bits [1:0] are ignored and treated as 0.
- `instr_valid` out 1: queue head valid.
- `instr_ready` in 1: core consumes the head.
- `instr` out 32: head instruction word.
- `instr_pc` out 32: address of the head instruction.

## Operation
- State:
  - fetch PC `fpc`.
  - FIFO of {instr, pc}, `count` in 0..DEPTH.
  - `outstanding` (accepted requests with no response yet).
  - `drop` (stale responses still to discard).
- Request fire = `imem_req_valid & imem_req_ready`. Response fire = `imem_resp_valid`. Consume fire = `instr_valid & instr_ready`.
- Credit rule: `imem_req_valid` = 1 iff `count + outstanding < DEPTH`, evaluated on registered state. This guarantees every response has a free slot.
- `imem_req_addr` = `fpc`. It is held stable while `imem_req_valid` is high and the request is not accepted.
- On request fire: `fpc` increments by 4, wrapping modulo 2^32. The request's PC is recorded in a PC shadow FIFO of DEPTH entries.
- On response fire:
  - If `drop` > 0: the response is discarded and `drop` decrements.
  - Otherwise it is written to the FIFO with its shadow PC.
  - Response with `outstanding` = 0: ignored, no state change.
- FSM, two states:
  - RUN: normal operation.
  - DRAIN: `drop` > 0; requests may still issue.
  - RUN→DRAIN: on redirect with a nonzero next `outstanding`.
  - DRAIN→RUN: when `drop` reaches 0. A new redirect in DRAIN reloads `drop`.
- Redirect has highest priority. In a `redirect_valid` cycle:
  - FIFO is flushed (`count` becomes 0), and a consume in the same cycle is void.
  - `fpc` ← {`redirect_pc`[31:2], 2'b00}.
  - A response arriving in the same cycle is discarded.
  - A request accepted in the same cycle is counted as stale.
  - `drop` ← `outstanding` + req_fire − resp_fire.
- A simultaneous write and consume with `count` = DEPTH cannot occur: the credit rule prevents it.

## Timing
- Reset values while `rst` is high:
  - `imem_req_valid` 0, `imem_req_addr` = RESET_PC.
  - `instr_valid` 0, `instr` 0, `instr_pc` 0.
  - `count`, `outstanding` and `drop` are 0; state is RUN.
- First request: `imem_req_valid` = 1 in the first cycle after `rst` deasserts, with address RESET_PC.
- Response latency from memory: ≥1 cycle after request fire; responses return in request order.
- Fill latency: data written on response fire appears at the head (`instr_valid` = 1) in the next cycle. There is no combinational response→output path.
- `instr`, `instr_pc` and `instr_valid` come from registers or the FIFO head. They are stable while `instr_valid` is high and `instr_ready` is low.
- Redirect takes effect the next cycle: `instr_valid` = 0 and `imem_req_addr` = redirect target.
- Steady state with 1-cycle memory and `instr_ready` held high: one instruction per cycle.
- Reset asserted mid-operation clears all state on that edge, and in-flight responses arriving afterward are ignored. Because `outstanding` = 0 after reset, the memory must also be reset.

## Configuration
- `IFQ_STATS_EN` defined: adds two output ports, both reset to 0 and wrapping modulo 2^32.
  - `stat_fetched` out 32: count of instructions written into the FIFO.
  - `stat_dropped` out 32: count of responses discarded by flush.
- `IFQ_STATS_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset then stream: 1-cycle memory returning word = addr, `instr_ready` high → `instr_pc` sequence 0x0, 0x4, 0x8…, first `instr_valid` by cycle 3 after reset, then one per cycle.
- Back-pressure: `instr_ready` low for 10 cycles, DEPTH = 4 → exactly 4 requests issued, then `imem_req_valid` = 0. Release yields 0x0–0xC in order, none lost.
- Redirect with 3 requests in flight at 4-cycle latency, `redirect_pc` = 0x103 → the 3 stale responses are dropped. Next `instr_pc` = 0x100, and `stat_dropped` = 3 with the macro defined.
- Same-cycle redirect, response and request fire → that response is discarded, the new request is counted stale, and the first delivered `instr_pc` equals the redirect target.
- Wrap: `redirect_pc` = 0xFFFF_FFFC → delivered PCs are 0xFFFF_FFFC, then 0x0000_0000.
- Reset mid-DRAIN: `rst` held 1 cycle → all outputs at reset values; the next request address is RESET_PC.
